hazard_scoreboard: RTL and testbench
====================================

# hazard_scoreboard

Tracks the destination registers of instructions in flight in EXE, MEM and WB. From that record, it decides when the instruction in ID must stall, because the operand it needs cannot yet be forwarded or read from the register file. It is the producer-side companion to the forwarding logic: it exports the registered EXE/MEM destination and write-enable fields that forwarding compares against, and it raises the stall that forwarding alone cannot resolve. It sits beside the ID stage and drives the PC/IF-ID hold and the ID-EXE bubble insertion.

## Interface
- CNT_W, 32, width of the stall statistics counter
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- forward_en  in  1  1 = forwarding path active, 0 = forwarding disabled
- freeze  in  1  whole pipeline held this cycle (SRAM busy); no slot advances
- flush  in  1  instruction currently in ID is being killed (taken branch)
- id_valid  in  1  ID holds a real instruction
- src1  in  5  first source register of ID instruction
- src2  in  5  second source register of ID instruction
- uses_src2  in  1  src2 is really read: register-form ALU, BNE compare, or store data
- id_wb_en  in  1  ID instruction writes the register file
- id_mem_r_en  in  1  ID instruction is a load
- id_dest  in  5  destination register of ID instruction
- hazard_stall  out  1  hold PC and IF/ID, insert bubble into EXE
- exe_dest, mem_dest  out  5 each  registered destinations of EXE/MEM slots
- exe_wb_en, mem_wb_en  out  1 each  registered write enables, already qualified by slot valid
- stall_count  out  CNT_W  number of cycles in which a stall took effect

## Operation
- Three slots, EXE, MEM and WB, each holding {valid, wb_en, mem_r_en, dest}.
- Advance on a clock edge with freeze=0:
  - WB takes MEM.
  - MEM takes EXE.
  - EXE takes the ID fields if id_valid & ~flush & ~hazard_stall; otherwise EXE takes a bubble (valid=0).
- freeze=1: every slot and stall_count hold their values; hazard_stall is still driven.
- match(s, slot) = slot.valid & slot.wb_en & (slot.dest != 0) & (s == slot.dest).
- Source qualification:
  - src1 is always checked.
  - src2 is checked only when uses_src2=1.
- Stall condition when forward_en=1: a match against EXE with EXE.mem_r_en=1 (load-use). ALU results in EXE/MEM are forwarded, so they never stall.
- Stall condition when forward_en=0: any match against EXE or MEM. WB never stalls, because the register file writes in the first half-cycle and reads in the second.
- hazard_stall = id_valid & ~flush & condition. A flushed ID never stalls.
- Register r0 never creates a dependency, whatever wb_en says.
- The exe_*/mem_* outputs are the slot registers themselves; exe_wb_en = EXE.valid & EXE.wb_en, and likewise for MEM.
- stall_count increments on each edge where hazard_stall=1 and freeze=0. It saturates at all-ones and does not wrap.
- forward_en may change at any cycle and takes effect in that same cycle's stall decision.

## Timing
- Reset (rst=0, asynchronous): all slots become invalid with dest=0; exe/mem outputs are 0, stall_count is 0, and hazard_stall is 0 (slots are empty).
- Release of reset takes effect at the next rising edge; there are no extra idle cycles.
- hazard_stall is combinational from the slot registers and the ID inputs, and is valid in the same cycle the ID fields are presented.
- An ID instruction accepted at edge n appears on exe_* after edge n and on mem_* after edge n+1.
- Load-use with forwarding costs exactly 1 stall cycle. With forward_en=0, a dependency on the immediately preceding writer costs 2 cycles, and on the one before that, 1 cycle.
- freeze and stall together: the freeze hold wins, so the bubble is not inserted and the counter does not move. The stall re-evaluates once freeze drops.
- flush together with a stall: flush wins, hazard_stall=0, and EXE receives a bubble.
- Reset asserted mid-stall clears everything immediately; the stall deasserts asynchronously.

## Test plan
- Forwarding on, load-use: `lw r3` then `add r4,r3,r1` → hazard_stall=1 for 1 cycle; then the add enters EXE, exe_dest=4 and mem_dest=3; stall_count=1.
- Forwarding off, back-to-back ALU: `add r3,..` then `sub r5,r3,r3` → stall 2 cycles; with one independent instruction between them → stall 1 cycle; stall_count ends at 3.
- Zero register and src2 gating:
  - Load with dest r0, then `add r4,r0,r0` → no stall.
  - `addi r6,r3,imm` (uses_src2=0, src2=3) behind `lw r3` → stall only via src1 when src1=3.
  - With src1≠3, no stall.
- Freeze: load-use stall present and freeze held 4 cycles → hazard_stall stays 1, the slots and stall_count are unchanged. Freeze drops → exactly 1 counted stall cycle.
- Flush: load-use condition with flush=1 → hazard_stall=0 and EXE gets a bubble (exe_wb_en=0 next cycle).
- Reset mid-operation: pull rst low during a stall → hazard_stall, exe/mem outputs and stall_count all 0 immediately. With CNT_W=4, 16 more stall cycles leave stall_count saturated at 15.

Source files
------------

// File: rtl/hazard_scoreboard.sv
// ============================================================================
// Module      : hazard_scoreboard
// Description : Tracks EXE/MEM destinations in flight and raises the ID stall
//               that operand forwarding cannot resolve.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hazard_scoreboard #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             forward_en,
   input  logic             freeze,
   input  logic             flush,
   input  logic             id_valid,
   input  logic [4:0]       src1,
   input  logic [4:0]       src2,
   input  logic             uses_src2,
   input  logic             id_wb_en,
   input  logic             id_mem_r_en,
   input  logic [4:0]       id_dest,
   output logic             hazard_stall,
   output logic [4:0]       exe_dest,
   output logic [4:0]       mem_dest,
   output logic             exe_wb_en,
   output logic             mem_wb_en,
   output logic [CNT_W-1:0] stall_count
);

   localparam logic [CNT_W-1:0] C_CNT_MAX = '1;
   localparam logic [CNT_W-1:0] C_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   // WB is not stored: it never causes a stall and drives no output.
   logic r_exe_valid;
   logic r_exe_wb;
   logic r_exe_mr;
   logic r_mem_valid;
   logic r_mem_wb;

   logic w_dep_exe;
   logic w_dep_mem;
   logic w_cond;
   logic w_accept;

   function automatic logic match(input logic [4:0] s, input logic v,
                                  input logic wb, input logic [4:0] d);
      return v & wb & (d != 5'd0) & (s == d);
   endfunction

   always_comb begin
      w_dep_exe = match(src1, r_exe_valid, r_exe_wb, exe_dest) |
                  (uses_src2 & match(src2, r_exe_valid, r_exe_wb, exe_dest));
      w_dep_mem = match(src1, r_mem_valid, r_mem_wb, mem_dest) |
                  (uses_src2 & match(src2, r_mem_valid, r_mem_wb, mem_dest));
      w_cond    = forward_en ? (w_dep_exe & r_exe_mr) : (w_dep_exe | w_dep_mem);
      hazard_stall = id_valid & ~flush & w_cond;
      w_accept     = id_valid & ~flush & ~hazard_stall;
   end

   assign exe_wb_en = r_exe_valid & r_exe_wb;
   assign mem_wb_en = r_mem_valid & r_mem_wb;

   // A bubble only clears valid; the remaining fields keep their last values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_exe_valid <= 1'b0;
         r_exe_wb    <= 1'b0;
         r_exe_mr    <= 1'b0;
         exe_dest    <= 5'd0;
         r_mem_valid <= 1'b0;
         r_mem_wb    <= 1'b0;
         mem_dest    <= 5'd0;
         stall_count <= '0;
      end else if (!freeze) begin
         r_mem_valid <= r_exe_valid;
         r_mem_wb    <= r_exe_wb;
         mem_dest    <= exe_dest;
         r_exe_valid <= w_accept;
         if (w_accept) begin
            r_exe_wb <= id_wb_en;
            r_exe_mr <= id_mem_r_en;
            exe_dest <= id_dest;
         end
         if (hazard_stall && (stall_count != C_CNT_MAX))
            stall_count <= stall_count + C_CNT_ONE;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_hazard_scoreboard.sv
// ============================================================================
// Module      : tb_hazard_scoreboard
// Description : Directed-vector scoreboard bench for hazard_scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_hazard_scoreboard;

   logic       clk = 1'b0;
   logic       rst;
   logic       forward_en, freeze, flush, id_valid;
   logic [4:0] src1, src2, id_dest;
   logic       uses_src2, id_wb_en, id_mem_r_en;
   logic       hazard_stall;
   logic [4:0] exe_dest, mem_dest;
   logic       exe_wb_en, mem_wb_en;
   logic [3:0] stall_count;

   typedef struct {
      logic       hs;
      logic [4:0] ed;
      logic [4:0] md;
      logic       ew;
      logic       mw;
      logic [3:0] cnt;
      string      name;
   } exp_t;

   exp_t q[$];
   int   total = 0;
   int   bad   = 0;

   hazard_scoreboard #(.CNT_W(4)) dut (
      .clk(clk), .rst(rst), .forward_en(forward_en), .freeze(freeze),
      .flush(flush), .id_valid(id_valid), .src1(src1), .src2(src2),
      .uses_src2(uses_src2), .id_wb_en(id_wb_en), .id_mem_r_en(id_mem_r_en),
      .id_dest(id_dest), .hazard_stall(hazard_stall), .exe_dest(exe_dest),
      .mem_dest(mem_dest), .exe_wb_en(exe_wb_en), .mem_wb_en(mem_wb_en),
      .stall_count(stall_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input string fld, input logic [7:0] act,
                      input logic [7:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s.%s: got %0d expected %0d", nm, fld, act, exp);
      end
   endtask

   // Monitor: compares the queued expectation against the outputs mid-cycle.
   always @(negedge clk) begin
      if (q.size() > 0) begin
         exp_t e;
         e = q.pop_front();
         chk(e.name, "hazard_stall", {7'd0, hazard_stall}, {7'd0, e.hs});
         chk(e.name, "exe_dest",     {3'd0, exe_dest},     {3'd0, e.ed});
         chk(e.name, "mem_dest",     {3'd0, mem_dest},     {3'd0, e.md});
         chk(e.name, "exe_wb_en",    {7'd0, exe_wb_en},    {7'd0, e.ew});
         chk(e.name, "mem_wb_en",    {7'd0, mem_wb_en},    {7'd0, e.mw});
         chk(e.name, "stall_count",  {4'd0, stall_count},  {4'd0, e.cnt});
      end
   end

   // One cycle: drive ID/control inputs just after the edge, queue expectation.
   task automatic cyc(input logic r, input logic fe, input logic fz, input logic fl,
                      input logic iv, input logic [4:0] s1, input logic [4:0] s2,
                      input logic u2, input logic wb, input logic mr, input logic [4:0] d,
                      input logic ehs, input logic [4:0] eed, input logic [4:0] emd,
                      input logic eew, input logic emw, input logic [3:0] ecnt,
                      input string nm);
      exp_t e;
      @(posedge clk);
      #1;
      rst = r; forward_en = fe; freeze = fz; flush = fl; id_valid = iv;
      src1 = s1; src2 = s2; uses_src2 = u2; id_wb_en = wb; id_mem_r_en = mr;
      id_dest = d;
      e.hs = ehs; e.ed = eed; e.md = emd; e.ew = eew; e.mw = emw; e.cnt = ecnt;
      e.name = nm;
      q.push_back(e);
   endtask

   function automatic logic [3:0] sat(input int v);
      return (v > 15) ? 4'd15 : v[3:0];
   endfunction

   initial begin
      rst = 1'b0; forward_en = 1'b1; freeze = 1'b0; flush = 1'b0; id_valid = 1'b0;
      src1 = 0; src2 = 0; uses_src2 = 0; id_wb_en = 0; id_mem_r_en = 0; id_dest = 0;

      //  r  fe fz fl iv s1 s2 u2 wb mr d    hs ed md ew mw cnt
      cyc(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, "reset");
      cyc(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, "idle");
      // forwarding on: lw r3 ; add r4,r3,r1
      cyc(1, 1, 0, 0, 1, 1, 0, 0, 1, 1, 3,   0, 0, 0, 0, 0, 0, "lu_lw");
      cyc(1, 1, 0, 0, 1, 3, 1, 1, 1, 0, 4,   1, 3, 0, 1, 0, 0, "lu_stall");
      cyc(1, 1, 0, 0, 1, 3, 1, 1, 1, 0, 4,   0, 3, 3, 0, 1, 1, "lu_go");
      cyc(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 4, 3, 1, 0, 1, "lu_exe");
      cyc(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 4, 4, 0, 1, 1, "drain1");
      cyc(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 4, 4, 0, 0, 1, "drain2");
      // forwarding off: add r3 ; sub r5,r3,r3 (2 stalls)
      cyc(1, 0, 0, 0, 1, 1, 2, 1, 1, 0, 3,   0, 4, 4, 0, 0, 1, "nf_add");
      cyc(1, 0, 0, 0, 1, 3, 3, 1, 1, 0, 5,   1, 3, 4, 1, 0, 1, "nf_stall_exe");
      cyc(1, 0, 0, 0, 1, 3, 3, 1, 1, 0, 5,   1, 3, 3, 0, 1, 2, "nf_stall_mem");
      cyc(1, 0, 0, 0, 1, 3, 3, 1, 1, 0, 5,   0, 3, 3, 0, 0, 3, "nf_go");
      // add r3 ; independent r7 ; sub r5,r3,r3 (1 stall)
      cyc(1, 0, 0, 0, 1, 1, 2, 1, 1, 0, 3,   0, 5, 3, 1, 0, 3, "nf_add2");
      cyc(1, 0, 0, 0, 1, 1, 2, 1, 1, 0, 7,   0, 3, 5, 1, 1, 3, "nf_indep");
      cyc(1, 0, 0, 0, 1, 3, 3, 1, 1, 0, 5,   1, 7, 3, 1, 1, 3, "nf_stall_one");
      cyc(1, 0, 0, 0, 1, 3, 3, 1, 1, 0, 5,   0, 7, 7, 0, 1, 4, "nf_go2");
      cyc(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 5, 7, 1, 0, 4, "drain3");
      cyc(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 5, 5, 0, 1, 4, "drain4");
      // zero register: lw r0 ; add r4,r0,r0
      cyc(1, 1, 0, 0, 1, 1, 0, 0, 1, 1, 0,   0, 5, 5, 0, 0, 4, "r0_lw");
      cyc(1, 1, 0, 0, 1, 0, 0, 1, 1, 0, 4,   0, 0, 5, 1, 0, 4, "r0_nostall");
      // src2 gating: lw r3 ; addi r6,r1 with src2=3 unused
      cyc(1, 1, 0, 0, 1, 1, 0, 0, 1, 1, 3,   0, 4, 0, 1, 1, 4, "g_lw");
      cyc(1, 1, 0, 0, 1, 1, 3, 0, 1, 0, 6,   0, 3, 4, 1, 1, 4, "src2_gated");
      cyc(1, 1, 0, 0, 1, 1, 0, 0, 1, 1, 3,   0, 6, 3, 1, 1, 4, "g_lw2");
      // addi r6,r3 stalls via src1, held under freeze for 4 cycles
      cyc(1, 1, 1, 0, 1, 3, 3, 0, 1, 0, 6,   1, 3, 6, 1, 1, 4, "fz1");
      cyc(1, 1, 1, 0, 1, 3, 3, 0, 1, 0, 6,   1, 3, 6, 1, 1, 4, "fz2");
      cyc(1, 1, 1, 0, 1, 3, 3, 0, 1, 0, 6,   1, 3, 6, 1, 1, 4, "fz3");
      cyc(1, 1, 1, 0, 1, 3, 3, 0, 1, 0, 6,   1, 3, 6, 1, 1, 4, "fz4");
      cyc(1, 1, 0, 0, 1, 3, 3, 0, 1, 0, 6,   1, 3, 6, 1, 1, 4, "fz_release");
      cyc(1, 1, 0, 0, 1, 3, 3, 0, 1, 0, 6,   0, 3, 3, 0, 1, 5, "fz_go");
      // flush beats load-use stall
      cyc(1, 1, 0, 0, 1, 1, 0, 0, 1, 1, 3,   0, 6, 3, 1, 0, 5, "fl_lw");
      cyc(1, 1, 0, 1, 1, 3, 1, 1, 1, 0, 4,   0, 3, 6, 1, 1, 5, "flush_nostall");
      cyc(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 3, 3, 0, 1, 5, "flush_bubble");
      // reset asserted during a (frozen) stall clears immediately
      cyc(1, 1, 0, 0, 1, 1, 0, 0, 1, 1, 3,   0, 3, 3, 0, 0, 5, "rs_lw");
      cyc(1, 1, 1, 0, 1, 3, 1, 1, 1, 0, 4,   1, 3, 3, 1, 0, 5, "rs_stall");
      cyc(0, 1, 1, 0, 1, 3, 1, 1, 1, 0, 4,   0, 0, 0, 0, 0, 0, "rs_async");
      cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, "rs_after");
      // saturation: 8 x (add r3 ; sub r5,r3,r3 x3) = 16 stalls without forwarding
      for (int i = 0; i < 8; i++) begin
         if (i == 0)
            cyc(1, 0, 0, 0, 1, 1, 2, 1, 1, 0, 3,  0, 0, 0, 0, 0, sat(2*i), "sat_a");
         else
            cyc(1, 0, 0, 0, 1, 1, 2, 1, 1, 0, 3,  0, 5, 3, 1, 0, sat(2*i), "sat_a");
         cyc(1, 0, 0, 0, 1, 3, 3, 1, 1, 0, 5,  1, 3, (i == 0) ? 5'd0 : 5'd5, 1,
             (i == 0) ? 1'b0 : 1'b1, sat(2*i), "sat_b");
         cyc(1, 0, 0, 0, 1, 3, 3, 1, 1, 0, 5,  1, 3, 3, 0, 1, sat(2*i+1), "sat_c");
         cyc(1, 0, 0, 0, 1, 3, 3, 1, 1, 0, 5,  0, 3, 3, 0, 0, sat(2*i+2), "sat_d");
      end
      cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 5, 3, 1, 0, 15, "sat_hold");

      begin
         int waited = 0;
         while (q.size() > 0 && waited < 10) begin
            @(posedge clk);
            waited++;
         end
         if (q.size() > 0) begin
            total++;
            bad++;
            $display("FAIL drain: pending=%0d expected 0", q.size());
         end
      end
      @(posedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
